i_o_input_fifo: RTL and testbench
=================================

# i_o_input_fifo

Byte buffer placed directly downstream of the UART receive controller. It captures each received byte, signalled by a single-cycle `io_input_trigger` pulse with `io_input_value`, into a circular FIFO. Bytes are presented to the consumer (CPU I/O register or loader) through a first-word-fall-through valid/ready interface. Occupancy and a sticky overflow flag let software detect lost bytes.

## Interface

Parameters:
- `DEPTH`, 16: number of byte slots; power of two, at least 2.
- `PTR_SIZE`, `$clog2(DEPTH)`: read/write pointer width.
- `LEVEL_SIZE`, `$clog2(DEPTH + 1)`: occupancy counter width.

Ports:
- `clk`, input, 1: single clock, shared with the receive controller.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `io_input_trigger`, input, 1: one-cycle pulse; a received byte is valid on `io_input_value`.
- `io_input_value`, input, 8: received byte, sampled when `io_input_trigger` = 1.
- `out_valid`, output, 1: FIFO non-empty; `out_data` holds the oldest byte.
- `out_data`, output, 8: oldest byte; forced to 0 when `out_valid` = 0.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle (pop when `out_valid && out_ready`).
- `flush`, input, 1: synchronous discard of all stored bytes.
- `level`, output, LEVEL_SIZE: current occupancy, 0 to DEPTH.
- `overflow`, output, 1: sticky; a byte was dropped because the FIFO was full.
- `overflow_clear`, input, 1: synchronous clear of `overflow`.

## Operation

- Storage: DEPTH×8 memory (not reset), write pointer `wr_ptr`, read pointer `rd_ptr`, register `level`. Pointers wrap naturally modulo DEPTH (DEPTH−1 → 0).
- push_req = `io_input_trigger`; pop = `out_valid && out_ready`.
- push accepted when `level < DEPTH`, or when `level == DEPTH && pop` (a slot frees the same cycle).
- Accepted push: mem[wr_ptr] ← `io_input_value`; `wr_ptr`+1.
- Pop: `rd_ptr`+1.
- `level` next state:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH; never underflows (pop impossible when empty).
- Rejected push (full, no pop): byte discarded; `overflow` ← 1.
- `overflow_clear`: `overflow` ← 0, unless an overflow event occurs the same cycle; set wins.
- `flush`: `wr_ptr`, `rd_ptr`, `level` ← 0. Same-cycle push and pop are ignored; a same-cycle trigger byte is lost and does not set `overflow`. `overflow` is otherwise unaffected by flush.
- `out_valid` = (`level != 0`). `out_data` = mem[rd_ptr] when valid, else 0 (combinational from registered state).
- `out_ready` while `out_valid` = 0 has no effect.

## Timing

- Reset (`rst_n` low, asynchronous assert): `out_valid` 0, `out_data` 0, `level` 0, `overflow` 0, pointers 0. Release is synchronised by the clock domain; the first push is possible on the first rising edge after deassertion.
- Reset mid-operation: all stored bytes are lost immediately; outputs take reset values without waiting for a clock edge.
- Write latency: trigger sampled at edge N; `out_valid`, `out_data`, and `level` reflect the byte after edge N (visible in cycle N+1).
- Empty FIFO with trigger and `out_ready` high in the same cycle: no pop (`out_valid` was 0). The byte appears next cycle.
- Pop: data advances to the next byte after the accepting edge. Back-to-back pops are allowed every cycle.
- Throughput: one push and one pop per cycle sustained. UART byte rate is far below the clock rate, so triggers are never adjacent in practice, but back-to-back triggers must still be handled.
- `flush` and `overflow_clear` take effect at the next rising edge.

## Test plan

- Reset, then triggers with 0x41, 0x42, 0x43 and `out_ready` = 0 → `level` = 3, `out_valid` = 1, `out_data` = 0x41. Then `out_ready` = 1 for 3 cycles → `out_data` reads 0x41, 0x42, 0x43, then `out_valid` = 0, `out_data` = 0, `level` = 0.
- DEPTH = 16: push 0x00..0x0F, then push 0xAA with no pop → `level` = 16, 0xAA dropped, `overflow` = 1. Drain 16 pops → 0x00..0x0F in order. Assert `overflow_clear` → `overflow` = 0.
- Full FIFO: trigger 0x55 in the same cycle as a pop → no overflow, `level` stays 16, and 0x55 is the last byte drained.
- Wrap-around: 40 push/pop pairs of an incrementing pattern with `level` ≤ 3 → output sequence matches input exactly across pointer wrap.
- `overflow_clear` in the same cycle as a full-FIFO dropped push → `overflow` remains 1. `flush` with `level` = 5 plus a concurrent trigger → `level` = 0, `out_valid` = 0, `overflow` unchanged.
- Assert `rst_n` low asynchronously (between edges) with `level` = 4 → `out_valid` and `level` go to 0 before the next edge. After release, push 0x7E → `out_data` = 0x7E one cycle later.

Source files
------------

// File: rtl/i_o_input_fifo.sv
// i_o_input_fifo
// Byte buffer behind the UART receive controller. Each io_input_trigger pulse
// captures io_input_value into a circular FIFO. The consumer reads the bytes
// through a first-word-fall-through valid/ready port. A level counter and a
// sticky overflow flag let software detect dropped bytes.
//
// Handshake: out_valid is high whenever the FIFO holds a byte, and out_data
// then shows the oldest byte. A transfer (pop) happens on a rising edge where
// out_valid && out_ready. out_valid never depends on out_ready, and out_ready
// has no effect while out_valid is low. The producer side has no
// backpressure: a trigger that finds the FIFO full with no pop in the same
// cycle is dropped and latches overflow.
//
// DEPTH must be a power of two (at least 2), so the pointers wrap modulo
// DEPTH on their own.
module i_o_input_fifo #(
  parameter int DEPTH      = 16,
  parameter int PTR_SIZE   = $clog2(DEPTH),
  parameter int LEVEL_SIZE = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_input_trigger,
  input  logic [7:0]            io_input_value,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [LEVEL_SIZE-1:0] level,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam logic [LEVEL_SIZE-1:0] LEVEL_FULL = LEVEL_SIZE'(DEPTH);
  localparam logic [PTR_SIZE-1:0]   PTR_ONE    = PTR_SIZE'(1);
  localparam logic [LEVEL_SIZE-1:0] LEVEL_ONE  = LEVEL_SIZE'(1);

  // Byte storage; contents are don't-care until written, so it is not reset.
  logic [7:0] mem [DEPTH];

  logic [PTR_SIZE-1:0]   wr_ptr;
  logic [PTR_SIZE-1:0]   rd_ptr;
  logic [LEVEL_SIZE-1:0] level_q;

  logic handshake;     // consumer accepts the head byte this cycle
  logic full;          // every slot is occupied
  logic pop;           // head byte is retired at this edge
  logic push;          // incoming byte is written at this edge
  logic overflow_evt;  // incoming byte is dropped because there is no room

  // Derive the per-cycle push/pop decisions from the registered state.
  // A flush cancels both, and a byte arriving with a flush is lost without
  // counting as an overflow.
  always_comb begin
    handshake    = 1'b0;
    full         = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;
    overflow_evt = 1'b0;
    handshake    = out_valid && out_ready;
    full         = (level_q == LEVEL_FULL);
    pop          = handshake && !flush;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    push         = io_input_trigger && !flush && (!full || handshake);
    overflow_evt = io_input_trigger && !flush && full && !handshake;
  end

  // Write accepted bytes into the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= io_input_value;
    end
  end

  // Pointer and occupancy bookkeeping. Flush returns everything to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Push and pop in the same cycle leave the level unchanged.
      case ({push, pop})
        2'b10:   level_q <= level_q + LEVEL_ONE;
        2'b01:   level_q <= level_q - LEVEL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow. A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (overflow_evt) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  // Present the head byte, forced to zero while empty so idle reads are clean.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_valid = (level_q != '0);
    if (out_valid) begin
      out_data = mem[rd_ptr];
    end
  end

  assign level = level_q;

endmodule

// File: tb/tb_i_o_input_fifo.sv
// Testbench for i_o_input_fifo. The reference model is a byte queue plus a
// flag: accepted bytes are appended to exp_q, a flush empties it, and the
// head is retired when the monitor sees a transfer. The monitor compares the
// DUT outputs against this model at every falling edge.
module tb_i_o_input_fifo;

  localparam int DEPTH      = 16;
  localparam int LEVEL_SIZE = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rst_n;
  logic                  io_input_trigger;
  logic [7:0]            io_input_value;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic                  out_ready;
  logic                  flush;
  logic [LEVEL_SIZE-1:0] level;
  logic                  overflow;
  logic                  overflow_clear;

  logic [7:0] exp_q[$];
  logic       exp_ovf;
  int         vectors;
  int         miscompares;

  i_o_input_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .io_input_trigger (io_input_trigger),
    .io_input_value   (io_input_value),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .flush            (flush),
    .level            (level),
    .overflow         (overflow),
    .overflow_clear   (overflow_clear)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares against the model, and retires the
  // head on a transfer.
  always @(negedge clk) begin
    check("level", int'(level), exp_q.size());
    check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", int'(out_data), int'(exp_q[0]));
    end else begin
      check("out_data_idle", int'(out_data), 0);
    end
    check("overflow", int'(overflow), int'(exp_ovf));
    if (out_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Entered just after a rising edge. Drives one cycle of inputs and applies
  // the model update belonging to the next rising edge.
  task automatic step(input logic trig, input logic [7:0] val, input logic rdy,
                      input logic fl, input logic oclr);
    int   sz;
    logic pop_m;
    logic push_m;
    logic ovf_m;
    io_input_trigger = trig;
    io_input_value   = val;
    out_ready        = rdy;
    flush            = fl;
    overflow_clear   = oclr;
    sz     = exp_q.size();
    pop_m  = rdy && (sz != 0);
    push_m = trig && !fl && ((sz < DEPTH) || pop_m);
    ovf_m  = trig && !fl && (sz == DEPTH) && !pop_m;
    @(negedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else if (push_m) begin
      exp_q.push_back(val);
    end
    if (ovf_m) begin
      exp_ovf = 1'b1;
    end else if (oclr) begin
      exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors          = 0;
    miscompares      = 0;
    exp_ovf          = 1'b0;
    rst_n            = 1'b0;
    io_input_trigger = 1'b0;
    io_input_value   = 8'h00;
    out_ready        = 1'b0;
    flush            = 1'b0;
    overflow_clear   = 1'b0;

    // Power-on reset
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Three bytes, then drain them
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    idle(1);
    drain(3);
    idle(1);

    // Fill to DEPTH, drop one byte, then push onto a full FIFO while popping
    fill(DEPTH, 8'h00);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    drain(DEPTH);
    idle(1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Clear collides with a drop, then flush at level 5 with a trigger
    fill(DEPTH, 8'h20);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain(DEPTH - 5);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Pointer wrap with a small occupancy
    for (int i = 0; i < 40; i++) step(1'b1, 8'h60 + 8'(i), (i >= 2), 1'b0, 1'b0);
    drain(3);
    idle(1);

    // Asynchronous reset between edges with four bytes stored
    fill(4, 8'hC0);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    idle(1);
    drain(1);

    // Randomised traffic, alternating producer-heavy and consumer-heavy phases
    for (int blk = 0; blk < 16; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 2 == 0) ? 15 : 85;
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < 55,
             8'($urandom_range(0, 255)),
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 199) < 2,
             $urandom_range(0, 99) < 3);
      end
    end
    drain(DEPTH + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
